// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag/result types and the ALU evaluation function.
package alu_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned SUM_W = MAX_W + 1;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_STORE = 2;
  localparam int unsigned OP_CALL  = 3;
  localparam int unsigned OP_RET   = 4;
  localparam int unsigned OP_SUB   = 5;
  localparam int unsigned OP_ADC   = 6;
  localparam int unsigned OP_CMP   = 7;

  typedef struct packed {
    logic cf;
    logic zf;
  } alu_flags_t;

  typedef struct packed {
    logic             c;
    logic [MAX_W-1:0] r;
  } alu_res_t;

  // Evaluate one op on w-bit unsigned operands; c is bit w of the (w+1)-bit result.
  function automatic alu_res_t alu_eval(input int unsigned     sel,
                                        input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input logic             cin,
                                        input int unsigned      w);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] mask;
    alu_res_t         res;
    mask = (SUM_W'(1) << w) - SUM_W'(1);
    case (sel)
      OP_ADD:          s = {1'b0, a} + {1'b0, b};
      OP_ADC:          s = {1'b0, a} + {1'b0, b} + SUM_W'(cin);
      OP_SUB, OP_CMP:  s = {1'b0, a} - {1'b0, b};
      OP_CALL, OP_RET: s = {1'b0, b};
      default:         s = {1'b0, a};
    endcase
    // A wrapped subtract sets every bit above w, so bit w doubles as the borrow.
    res.c = s[7'(w)];
    res.r = s[MAX_W-1:0] & mask[MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order output buffer; head entry drives dout directly from a register.
module alu_skid_buf #(
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] head_q, head_n;
  logic [DW-1:0] tail_q, tail_n;
  logic [1:0]    count_q, count_n;
  logic          pop;

  // Next occupancy and entry contents from push/pop.
  always_comb begin
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    pop     = out_valid & out_ready;
    if (pop && count_q == 2'd2) begin
      head_n = tail_q;
    end
    if (push) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        head_n = din;
      end else begin
        tail_n = din;
      end
    end
    count_n = count_q + 2'(push) - 2'(pop);
  end

  // Entry, occupancy and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      head_q    <= head_n;
      tail_q    <= tail_n;
      count_q   <= count_n;
      in_ready  <= (count_n < 2'd2);
      out_valid <= (count_n != 2'd0);
    end
  end

  assign dout = head_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with persistent CF/ZF and a 2-entry output buffer.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_cf,
  output logic             out_zf,
  output logic             cf,
  output logic             zf
);

  localparam int unsigned DW = WIDTH + 2;

  alu_flags_t       flags_q;
  alu_flags_t       flags_n;
  alu_res_t         res;
  logic [WIDTH-1:0] r;
  logic             accept;
  logic             push;
  logic             flag_op;
  logic [DW-1:0]    din;
  logic [DW-1:0]    dout;
  logic             unused_hi;

  // Decode, evaluate, and form the flags this op leaves behind.
  always_comb begin
    res     = alu_eval(32'(sel), MAX_W'(in1), MAX_W'(in2), flags_q.cf, WIDTH);
    r       = res.r[WIDTH-1:0];
    flag_op = (32'(sel) == OP_ADD) || (32'(sel) == OP_SUB) ||
              (32'(sel) == OP_ADC) || (32'(sel) == OP_CMP);
    flags_n = flags_q;
    if (flag_op) begin
      flags_n.cf = res.c;
      flags_n.zf = (r == '0);
    end
    accept = in_valid & in_ready;
    push   = accept & (32'(sel) != OP_CMP);
    din    = {r, flags_n};
  end

  assign unused_hi = ^res.r[MAX_W-1:WIDTH];

  // Live flags update on every accepted op so a following ADC sees them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept) begin
      flags_q <= flags_n;
    end
  end

  alu_skid_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .din       (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  assign out    = dout[DW-1:2];
  assign out_cf = dout[1];
  assign out_zf = dout[0];
  assign cf     = flags_q.cf;
  assign zf     = flags_q.zf;

endmodule
